zoom_sequencer: RTL

Control FSM that sequences the nearest-neighbour zoom scaler. It converts single-cycle zoom-in/zoom-out requests into a clamped `zoom_level`, and runs one complete scaler pass per accepted level change. It holds the level stable during each pass, bounds the pass with a watchdog, and swaps the double-buffered framebuffer once the scaler reports `done`. It sits between the debounced user controls and the scaler/framebuffer pair.

---
 rtl/zoom_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/zoom_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : zoom_sequencer
// Description : Control FSM for the nearest-neighbour zoom scaler. Turns
//               single-cycle zoom requests into a clamped zoom level, runs
//               one scaler pass per accepted level change under a watchdog,
//               and swaps the double-buffered framebuffer on completion.
// Ports       : clk           - single rising-edge clock
//               reset_n       - synchronous active-low reset
//               zoom_in       - one-cycle zoom-in request pulse
//               zoom_out      - one-cycle zoom-out request pulse
//               scaler_done   - scaler end-of-pass pulse
//               scaler_enable - scaler run (low holds scaler cleared)
//               zoom_level    - level presented to the scaler
//               buffer_sel    - framebuffer currently displayed
//               swap_pulse    - one-cycle pulse when buffer_sel toggles
//               busy          - high whenever the FSM is not idle
//               error         - sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
module zoom_sequencer #(
    parameter int ZOOM_MIN       = 2,
    parameter int ZOOM_MAX       = 4,
    parameter int ZOOM_RESET     = 2,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       zoom_in,
    input  logic       zoom_out,
    input  logic       scaler_done,
    output logic       scaler_enable,
    output logic [2:0] zoom_level,
    output logic       buffer_sel,
    output logic       swap_pulse,
    output logic       busy,
    output logic       error
);

    localparam int c_TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_SWAP  = 2'd3;

    localparam logic [1:0] c_PEND_NONE = 2'd0;
    localparam logic [1:0] c_PEND_IN   = 2'd1;
    localparam logic [1:0] c_PEND_OUT  = 2'd2;

    localparam logic [2:0] c_LVL_MIN   = 3'(ZOOM_MIN);
    localparam logic [2:0] c_LVL_MAX   = 3'(ZOOM_MAX);
    localparam logic [2:0] c_LVL_RESET = 3'(ZOOM_RESET);

    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_SAT  = '1;

    logic [1:0]           r_state;
    logic [1:0]           r_pending;
    logic [2:0]           r_prev_level;
    logic [c_TIMER_W-1:0] r_timer;

    logic       w_req;
    logic [1:0] w_pending_next;
    logic [1:0] w_pending_taken;

    // Exactly one of the two request lines counts as a request; both at
    // once cancel out and leave the slot untouched.
    always_comb begin
        w_req          = zoom_in ^ zoom_out;
        w_pending_next = r_pending;
        if (zoom_in && !zoom_out) begin
            w_pending_next = c_PEND_IN;
        end else if (zoom_out && !zoom_in) begin
            w_pending_next = c_PEND_OUT;
        end
        // When IDLE consumes the slot, a request arriving in that same
        // cycle is newer and takes its place instead of being lost.
        w_pending_taken = w_req ? w_pending_next : c_PEND_NONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= c_START;
            r_pending     <= c_PEND_NONE;
            r_prev_level  <= c_LVL_RESET;
            r_timer       <= '0;
            zoom_level    <= c_LVL_RESET;
            scaler_enable <= 1'b0;
            buffer_sel    <= 1'b0;
            swap_pulse    <= 1'b0;
            busy          <= 1'b1;
            error         <= 1'b0;
        end else begin
            r_pending <= w_pending_next;

            case (r_state)
                c_IDLE: begin
                    busy <= 1'b0;
                    if (r_pending == c_PEND_IN && zoom_level < c_LVL_MAX) begin
                        r_prev_level <= zoom_level;
                        zoom_level   <= zoom_level + 3'd1;
                        r_pending    <= w_pending_taken;
                        error        <= 1'b0;
                        r_state      <= c_START;
                        busy         <= 1'b1;
                    end else if (r_pending == c_PEND_OUT && zoom_level > c_LVL_MIN) begin
                        r_prev_level <= zoom_level;
                        zoom_level   <= zoom_level - 3'd1;
                        r_pending    <= w_pending_taken;
                        error        <= 1'b0;
                        r_state      <= c_START;
                        busy         <= 1'b1;
                    end else if (r_pending != c_PEND_NONE) begin
                        // Clamped request: drop it silently.
                        r_pending <= w_pending_taken;
                    end
                end

                c_START: begin
                    // Level was updated on the previous edge, so it is
                    // already stable when enable rises here.
                    scaler_enable <= 1'b1;
                    r_timer       <= '0;
                    r_state       <= c_RUN;
                    busy          <= 1'b1;
                end

                c_RUN: begin
                    if (r_timer != c_TIMER_SAT) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    if (scaler_done) begin
                        scaler_enable <= 1'b0;
                        swap_pulse    <= 1'b1;
                        buffer_sel    <= ~buffer_sel;
                        r_state       <= c_SWAP;
                        busy          <= 1'b1;
                    end else if (r_timer == c_TIMER_LAST) begin
                        // Abort: restore the level the displayed buffer
                        // was rendered at and skip the swap.
                        scaler_enable <= 1'b0;
                        error         <= 1'b1;
                        zoom_level    <= r_prev_level;
                        r_state       <= c_IDLE;
                        busy          <= 1'b0;
                    end else begin
                        busy <= 1'b1;
                    end
                end

                c_SWAP: begin
                    swap_pulse <= 1'b0;
                    r_state    <= c_IDLE;
                    busy       <= 1'b0;
                end

                default: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
